de10_bus_arbiter: RTL
=====================

# de10_bus_arbiter

Two-master arbiter in front of the DE10 address-decoded bus (SRAM / peripherals / SDRAM regions selected by addr[31:22]). It shares the single bus port between the instruction-fetch master (m0) and the load/store master (m1), using round-robin priority. Each transfer is sequenced with a valid/ready handshake toward the bus. Accesses to unmapped regions, and transfers the bus never answers (timeout), complete with an error response.

## Interface
Parameters:
- TIMEOUT, 255, max BUSY cycles waiting for bus_ready before error completion (1..2^TW-1)
- TW, 8, width of the timeout counter

Clock and reset:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset

Master m0 (fetch):
- m0_req  in  1  request; held high with addr/we/wdata stable until m0_ack
- m0_addr  in  32  byte address
- m0_we  in  1  1 = write, 0 = read
- m0_wdata  in  32  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  valid with m0_ack; 1 = unmapped region or timeout
- m0_rdata  out  32  read data, valid with m0_ack

Master m1 (load/store):
- m1_req, m1_addr, m1_we, m1_wdata, m1_ack, m1_err, m1_rdata — same as m0

Bus side:
- bus_valid  out  1  transfer active
- bus_addr  out  32  latched address
- bus_we  out  1  latched write enable
- bus_wdata  out  32  latched write data
- bus_rdata  in  32  read data, sampled when bus_ready=1
- bus_ready  in  1  slave completion; ignored unless bus_valid=1

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If no request, stay in IDLE.
  - With exactly one requester, grant it. With both requesting, grant the master not in last_grant.
  - On grant, latch addr/we/wdata and the grant index, update last_grant, and clear the counter.
  - If the latched addr[31:22] > 10'h2 (unmapped), go to RESP with err=1 and rdata=0. Otherwise go to BUSY.
- BUSY:
  - bus_valid=1, bus outputs driven from the latched registers.
  - On bus_ready=1: latch bus_rdata (store 0 on writes), err=0, go to RESP.
  - Else if counter == TIMEOUT-1: err=1, rdata=0, go to RESP.
  - Else counter+1. Counter is TW bits and never wraps, because it exits at TIMEOUT-1.
- RESP: assert ack for the granted master only, with the latched err/rdata, then go to IDLE unconditionally.
- m0_rdata and m1_rdata both carry the latched rdata register. A master qualifies it with its own ack.
- A req that drops mid-transfer does not abort the transfer; ack still pulses.
- A master that keeps req high after its ack is treated as issuing a new request in the following IDLE cycle.
- Reset values:
  - state=IDLE, last_grant=m1 (so m0 wins the first contention).
  - bus_valid=0, m0_ack=m1_ack=0, m0_err=m1_err=0.
  - rdata=0, bus_addr=0, bus_we=0, bus_wdata=0, counter=0.
- Reset asserted mid-transfer: the transfer is discarded, no ack is issued, and all outputs take reset values on the next edge.

## Timing
- Grant is decided in the IDLE cycle (N).
- BUSY starts at N+1 with bus_valid=1.
- If bus_ready is sampled high at cycle M, ack is high at M+1.
- Minimum req-to-ack latency is 3 cycles: req seen at N, bus_ready at N+1, ack at N+2.
- Unmapped access: ack+err at N+1, and bus_valid never asserts.
- Timeout: bus_valid is high for exactly TIMEOUT cycles, then ack+err follows on the next cycle.
- Back-to-back transfers from the same master: minimum period 3 cycles (IDLE, BUSY, RESP).
- bus_ready while not in BUSY has no effect.
- Ack is a single-cycle pulse. m0_ack and m1_ack are never high in the same cycle.
- All outputs are registered; none depend combinationally on inputs.

## Test plan
- m0 read of 0x0000_0010, bus_ready at first BUSY cycle with bus_rdata=0xDEADBEEF:
  - m0_ack at req+2, m0_rdata=0xDEADBEEF, m0_err=0, m1_ack stays 0.
- m0 and m1 request together for three transfers each, bus_ready immediate:
  - grant order is m0, m1, m0, m1, m0, m1.
  - bus_addr matches the granted master's addr each time.
- m1 write to 0x0080_0004 (tag 2), wdata=0x12345678, bus_ready after 4 BUSY cycles:
  - bus_we=1 and bus_wdata=0x12345678 held throughout BUSY.
  - m1_ack with m1_rdata=0 and m1_err=0.
- m0 read of 0xFFC0_0000 (tag 0x3FF):
  - no bus_valid pulse.
  - m0_ack with m0_err=1 and m0_rdata=0 one cycle after grant.
- TIMEOUT=4, bus_ready held 0:
  - bus_valid high exactly 4 cycles, then m1_ack with m1_err=1.
  - The next IDLE then serves the pending m0 request.
- rst pulsed during BUSY:
  - next cycle bus_valid=0, no ack, state IDLE.
  - first subsequent contention goes to m0.

Source files
------------

// File: rtl/de10_bus_arbiter.sv
// Round-robin arbiter sharing one DE10 bus port between the fetch (m0) and
// load/store (m1) masters, with unmapped-region and timeout error completion.
//
// state | meaning
// IDLE  | waiting for a request; grant and request latching happen here
// BUSY  | bus_valid high, waiting for bus_ready or the timeout
// RESP  | one-cycle ack to the granted master with latched err/rdata
module de10_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        gnt_q, last_grant;
  logic        grant_any, grant_idx, unmapped;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic [31:0] sel_wdata;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        we_q, err_q;
  logic [TW-1:0] cnt;

  always_comb begin
    state_nxt = state;
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (m0_req && m1_req) begin
      grant_any = 1'b1;
      grant_idx = ~last_grant;
    end else if (m0_req) begin
      grant_any = 1'b1;
    end else if (m1_req) begin
      grant_any = 1'b1;
      grant_idx = 1'b1;
    end
    sel_addr  = grant_idx ? m1_addr  : m0_addr;
    sel_we    = grant_idx ? m1_we    : m0_we;
    sel_wdata = grant_idx ? m1_wdata : m0_wdata;
    // Only tags 0..2 (SRAM, peripherals, SDRAM) are decoded on the bus.
    unmapped  = sel_addr[31:22] > 10'h2;
    case (state)
      IDLE:    if (grant_any) state_nxt = unmapped ? RESP : BUSY;
      BUSY:    if (bus_ready || cnt == CNT_LAST) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_any) begin
            gnt_q      <= grant_idx;
            last_grant <= grant_idx;
            addr_q     <= sel_addr;
            we_q       <= sel_we;
            wdata_q    <= sel_wdata;
            cnt        <= '0;
            if (unmapped) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        BUSY: begin
          if (bus_ready) begin
            rdata_q <= we_q ? 32'h0 : bus_rdata;
            err_q   <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only, so nothing is combinational from inputs.
  assign bus_valid = (state == BUSY);
  assign bus_addr  = addr_q;
  assign bus_we    = we_q;
  assign bus_wdata = wdata_q;
  assign m0_ack    = (state == RESP) && !gnt_q;
  assign m1_ack    = (state == RESP) &&  gnt_q;
  assign m0_err    = m0_ack && err_q;
  assign m1_err    = m1_ack && err_q;
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;

endmodule
